// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg: shared widths, opcode constants, FSM states and destination decode
package writeback_unit_pkg;

    localparam int WB_DATA_W = 8;
    localparam int WB_REG_AW = 3;
    localparam int WB_MEM_AW = 5;

    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_STORE = 4'b1101;
    localparam logic [3:0] OP_NOP   = 4'b1111;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SINGLE = 3'd1,
        WR_LO     = 3'd2,
        WR_HI     = 3'd3,
        WR_MEM    = 3'd4
    } state_t;

    // First state an accepted instruction enters; am only matters for stores
    function automatic state_t first_state(input logic [3:0] op, input logic am);
        return (op == OP_MUL || op == OP_DIV) ? WR_LO :
               (op == OP_STORE && am)         ? WR_MEM :
               (op == OP_NOP)                 ? IDLE : WR_SINGLE;
    endfunction

endpackage

// File: rtl/writeback_unit.sv
// writeback_unit: commits execute results to the register file or memory bank write port
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int REG_AW = WB_REG_AW,
    parameter int MEM_AW = WB_MEM_AW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          opcode,
    input  logic                am,
    input  logic [REG_AW-1:0]   rd,
    input  logic [MEM_AW-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   result,
    input  logic [2*DATA_W-1:0] result_md,
    output logic                reg_we,
    output logic [REG_AW-1:0]   reg_waddr,
    output logic [DATA_W-1:0]   reg_wdata,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_waddr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                done
);

    state_t              state_q, state_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [2*DATA_W-1:0] md_q, md_d;
    logic                ready_q, ready_d;
    logic                reg_we_q, reg_we_d, mem_we_q, mem_we_d, done_q, done_d;
    logic [REG_AW-1:0]   reg_waddr_q, reg_waddr_d;
    logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d, mem_wdata_q, mem_wdata_d;
    logic [MEM_AW-1:0]   mem_waddr_q, mem_waddr_d;
    logic                transfer;

    assign transfer = in_valid && ready_q;

    // Next state, operand capture, and next-cycle output values derived from the
    // state being entered so every port comes straight from a flop
    always_comb begin
        rd_d        = transfer ? rd        : rd_q;
        addr_d      = transfer ? mem_addr  : addr_q;
        res_d       = transfer ? result    : res_q;
        md_d        = transfer ? result_md : md_q;
        state_d     = transfer ? first_state(opcode, am) :
                      (state_q == WR_LO) ? WR_HI : IDLE;
        ready_d     = (state_d == IDLE);
        reg_we_d    = (state_d == WR_SINGLE) || (state_d == WR_LO) || (state_d == WR_HI);
        reg_waddr_d = (state_d == WR_HI) ? rd_d + 1'b1 : reg_we_d ? rd_d : '0;
        reg_wdata_d = (state_d == WR_SINGLE) ? res_d :
                      (state_d == WR_LO)     ? md_d[DATA_W-1:0] :
                      (state_d == WR_HI)     ? md_d[2*DATA_W-1:DATA_W] : '0;
        mem_we_d    = (state_d == WR_MEM);
        mem_waddr_d = mem_we_d ? addr_d : '0;
        mem_wdata_d = mem_we_d ? res_d : '0;
        done_d      = (state_d == WR_SINGLE) || (state_d == WR_HI) || (state_d == WR_MEM) ||
                      (transfer && opcode == OP_NOP);
    end

    // State, captured operands and registered outputs; reset drops any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_q        <= '0;
            addr_q      <= '0;
            res_q       <= '0;
            md_q        <= '0;
            ready_q     <= 1'b1;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            res_q       <= res_d;
            md_q        <= md_d;
            ready_q     <= ready_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = ready_q;
    assign reg_we    = reg_we_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: randomized and directed checks of writeback_unit against a write-list model
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = 4'd0;
    logic        am = 1'b0;
    logic [2:0]  rd = 3'd0;
    logic [4:0]  mem_addr = 5'd0;
    logic [7:0]  result = 8'd0;
    logic [15:0] result_md = 16'd0;
    logic        reg_we, mem_we, done;
    logic [2:0]  reg_waddr;
    logic [7:0]  reg_wdata, mem_wdata;
    logic [4:0]  mem_waddr;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       rwe;
        logic [2:0] ra;
        logic [7:0] rdat;
        logic       mwe;
        logic [4:0] ma;
        logic [7:0] mdat;
        logic       dn;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];

    writeback_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .am(am), .rd(rd), .mem_addr(mem_addr), .result(result),
        .result_md(result_md), .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .done(done)
    );

    always #5 clk = ~clk;

    // Reference: the list of per-cycle port values an instruction must produce
    task automatic build_expect(input logic [3:0] op, input logic a, input logic [2:0] r,
                                input logic [4:0] ma, input logic [7:0] res, input logic [15:0] md);
        logic [2:0] r1;
        r1 = r + 3'd1;
        exp_q.delete();
        if (op == 4'b1111) begin
            exp_q.push_back('{1'b0, 3'd0, 8'd0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b1});
        end else if (op == 4'b1010 || op == 4'b1011) begin
            exp_q.push_back('{1'b1, r, md[7:0], 1'b0, 5'd0, 8'd0, 1'b0, 1'b0});
            exp_q.push_back('{1'b1, r1, md[15:8], 1'b0, 5'd0, 8'd0, 1'b1, 1'b0});
        end else if (op == 4'b1101 && a) begin
            exp_q.push_back('{1'b0, 3'd0, 8'd0, 1'b1, ma, res, 1'b1, 1'b0});
        end else begin
            exp_q.push_back('{1'b1, r, res, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0});
        end
        exp_q.push_back('{1'b0, 3'd0, 8'd0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b1});
    endtask

    // Issue one instruction, scramble inputs after the handshake, and check every following cycle
    task automatic run_instr(input string nm, input logic [3:0] op, input logic a, input logic [2:0] r,
                             input logic [4:0] ma, input logic [7:0] res, input logic [15:0] md);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_before_issue got=%b want=1", nm, in_ready);
        end
        opcode = op; am = a; rd = r; mem_addr = ma; result = res; result_md = md; in_valid = 1'b1;
        build_expect(op, a, r, ma, res, md);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode = 4'($urandom); am = 1'($urandom); rd = 3'($urandom);
        mem_addr = 5'($urandom); result = 8'($urandom); result_md = 16'($urandom);
        foreach (exp_q[i]) begin
            @(negedge clk);
            total++;
            if (reg_we !== exp_q[i].rwe) begin
                bad++;
                $display("FAIL %s c%0d reg_we got=%b want=%b", nm, i, reg_we, exp_q[i].rwe);
            end
            if (exp_q[i].rwe) begin
                total++;
                if (reg_waddr !== exp_q[i].ra || reg_wdata !== exp_q[i].rdat) begin
                    bad++;
                    $display("FAIL %s c%0d reg_write got=%0d:%h want=%0d:%h", nm, i,
                             reg_waddr, reg_wdata, exp_q[i].ra, exp_q[i].rdat);
                end
            end
            total++;
            if (mem_we !== exp_q[i].mwe) begin
                bad++;
                $display("FAIL %s c%0d mem_we got=%b want=%b", nm, i, mem_we, exp_q[i].mwe);
            end
            if (exp_q[i].mwe) begin
                total++;
                if (mem_waddr !== exp_q[i].ma || mem_wdata !== exp_q[i].mdat) begin
                    bad++;
                    $display("FAIL %s c%0d mem_write got=%0d:%h want=%0d:%h", nm, i,
                             mem_waddr, mem_wdata, exp_q[i].ma, exp_q[i].mdat);
                end
            end
            total++;
            if (done !== exp_q[i].dn || in_ready !== exp_q[i].rdy) begin
                bad++;
                $display("FAIL %s c%0d done/ready got=%b/%b want=%b/%b", nm, i,
                         done, in_ready, exp_q[i].dn, exp_q[i].rdy);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({reg_we, mem_we, done, reg_waddr, reg_wdata, mem_waddr, mem_wdata} !== 30'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {reg_we, mem_we, done, reg_waddr, reg_wdata, mem_waddr, mem_wdata});
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || reg_we !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_release ready/rwe/mwe/done got=%b%b%b%b want=1000",
                     in_ready, reg_we, mem_we, done);
        end
    endtask

    task automatic test_directed();
        run_instr("add",       4'b0000, 1'b0, 3'd3, 5'd0,  8'h5A, 16'h0000);
        run_instr("mul",       4'b1010, 1'b0, 3'd2, 5'd0,  8'h00, 16'hBEEF);
        run_instr("div_wrap",  4'b1011, 1'b0, 3'd7, 5'd0,  8'h00, 16'h1234);
        run_instr("store_mem", 4'b1101, 1'b1, 3'd0, 5'd31, 8'hC3, 16'h0000);
        run_instr("store_reg", 4'b1101, 1'b0, 3'd1, 5'd9,  8'hC3, 16'h0000);
        run_instr("nop",       4'b1111, 1'b1, 3'd4, 5'd4,  8'hFF, 16'hFFFF);
        run_instr("mul_am",    4'b1010, 1'b1, 3'd6, 5'd3,  8'h11, 16'h8001);
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: op = 4'b1010;
                1: op = 4'b1011;
                2: op = 4'b1101;
                3: op = 4'b1111;
                default: op = 4'($urandom);
            endcase
            run_instr("random", op, 1'($urandom), 3'($urandom), 5'($urandom),
                      8'($urandom), 16'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        opcode = 4'b1010; am = 1'b0; rd = 3'd6; result_md = 16'hA55A; in_valid = 1'b1;
        @(posedge clk);
        #1;
        opcode = 4'b0001; rd = 3'd4; result = 8'h77; result_md = 16'h0000;
        @(negedge clk);
        total++;
        if ({reg_we, reg_waddr, reg_wdata, done, in_ready} !== {1'b1, 3'd6, 8'h5A, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL b2b_lo got=%b/%0d/%h/%b/%b want=1/6/5a/0/0", reg_we, reg_waddr, reg_wdata, done, in_ready);
        end
        @(negedge clk);
        total++;
        if ({reg_we, reg_waddr, reg_wdata, done, in_ready} !== {1'b1, 3'd7, 8'hA5, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL b2b_hi got=%b/%0d/%h/%b/%b want=1/7/a5/1/0", reg_we, reg_waddr, reg_wdata, done, in_ready);
        end
        @(negedge clk);
        total++;
        if (reg_we !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_gap rwe/done/ready got=%b%b%b want=001", reg_we, done, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({reg_we, reg_waddr, reg_wdata, done, in_ready} !== {1'b1, 3'd4, 8'h77, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL b2b_add got=%b/%0d/%h/%b/%b want=1/4/77/1/0", reg_we, reg_waddr, reg_wdata, done, in_ready);
        end
        @(negedge clk);
        total++;
        if (reg_we !== 1'b0 || mem_we !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_end rwe/mwe/ready got=%b%b%b want=001", reg_we, mem_we, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        opcode = 4'b1010; am = 1'b0; rd = 3'd5; result_md = 16'hABCD; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (reg_we !== 1'b1 || reg_wdata !== 8'hCD) begin
            bad++;
            $display("FAIL rst_mid_lo got=%b/%h want=1/cd", reg_we, reg_wdata);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({reg_we, mem_we, done, reg_waddr, reg_wdata, mem_waddr, mem_wdata} !== 30'd0) begin
            bad++;
            $display("FAIL rst_mid_async got=%h want=0",
                     {reg_we, mem_we, done, reg_waddr, reg_wdata, mem_waddr, mem_wdata});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({reg_we, mem_we, done, reg_waddr, reg_wdata, mem_waddr, mem_wdata} !== 30'd0 ||
                in_ready !== 1'b1) begin
                bad++;
                $display("FAIL rst_mid_after%0d outs=%h ready=%b want=0/1", k,
                         {reg_we, mem_we, done, reg_waddr, reg_wdata, mem_waddr, mem_wdata}, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        run_instr("post_reset", 4'b0011, 1'b1, 3'd0, 5'd1, 8'h3C, 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
